// File: rtl/gpio_sfr_pkg.sv
// Shared definitions for the GPIO special-function register bank:
// register offsets within a port and the default port width.
package gpio_sfr_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned REG_W     = 3;

  localparam logic [REG_W-1:0] REG_IN    = 3'd0;
  localparam logic [REG_W-1:0] REG_OUT   = 3'd1;
  localparam logic [REG_W-1:0] REG_DIR   = 3'd2;
  localparam logic [REG_W-1:0] REG_IE    = 3'd3;
  localparam logic [REG_W-1:0] REG_IFLAG = 3'd4;
  localparam logic [REG_W-1:0] REG_SET   = 3'd5;
  localparam logic [REG_W-1:0] REG_CLR   = 3'd6;
  localparam logic [REG_W-1:0] REG_TGL   = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_sfr_bank.sv
// Memory-mapped GPIO register bank: per-port IN/OUT/DIR/IE/IFLAG with
// atomic set/clear/toggle aliases and a combined change interrupt.
module gpio_sfr_bank
  import gpio_sfr_pkg::*;
#(
  parameter  int unsigned WIDTH       = DEF_WIDTH,
  parameter  int unsigned PORTS       = 2,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned PW          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [PW+2:0]          addr,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rvalid,
  input  logic [PORTS*WIDTH-1:0] pin_in,
  output logic [PORTS*WIDTH-1:0] pin_out,
  output logic [PORTS*WIDTH-1:0] pin_oe,
  output logic                   irq
);

  logic [PW-1:0]          port_sel;
  logic [REG_W-1:0]       reg_sel;
  logic [PORTS*WIDTH-1:0] sync_all;
  logic [PORTS*WIDTH-1:0] ie_all;
  logic [PORTS*WIDTH-1:0] iflag_all;
  logic [PORTS-1:0]       pend;
  logic [WIDTH-1:0]       rd_mux;

  assign port_sel = addr[PW+2:REG_W];
  assign reg_sel  = addr[REG_W-1:0];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic             wr_hit;
    logic [WIDTH-1:0] sync_v, prev_q, out_q, dir_q, ie_q, iflag_q;
    logic [WIDTH-1:0] set_mask, clr_mask;

    // Out-of-range port indices never match, so such writes fall through.
    assign wr_hit = wr_en && (port_sel == PW'(p));

    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .RST (RST),
      .d   (pin_in[p*WIDTH +: WIDTH]),
      .q   (sync_v)
    );

    assign set_mask = (sync_v ^ prev_q) & ie_q;
    assign clr_mask = (wr_hit && reg_sel == REG_IFLAG) ? wdata : '0;

    always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
        prev_q  <= '0;
        out_q   <= '0;
        dir_q   <= '0;
        ie_q    <= '0;
        iflag_q <= '0;
      end else begin
        prev_q  <= sync_v;
        // Hardware set is ORed in after the W1C mask so a coincident change wins.
        iflag_q <= (iflag_q & ~clr_mask) | set_mask;
        if (wr_hit) begin
          case (reg_sel)
            REG_OUT: out_q <= wdata;
            REG_DIR: dir_q <= wdata;
            REG_IE:  ie_q  <= wdata;
            REG_SET: out_q <= out_q | wdata;
            REG_CLR: out_q <= out_q & ~wdata;
            REG_TGL: out_q <= out_q ^ wdata;
            default: ;
          endcase
        end
      end
    end

    assign pin_out[p*WIDTH +: WIDTH]   = out_q;
    assign pin_oe[p*WIDTH +: WIDTH]    = dir_q;
    assign sync_all[p*WIDTH +: WIDTH]  = sync_v;
    assign ie_all[p*WIDTH +: WIDTH]    = ie_q;
    assign iflag_all[p*WIDTH +: WIDTH] = iflag_q;
    assign pend[p]                     = |(iflag_q & ie_q);
  end

  // Read select; write-only offsets and absent ports return zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (port_sel == PW'(p)) begin
        case (reg_sel)
          REG_IN:    rd_mux = sync_all[p*WIDTH +: WIDTH];
          REG_OUT:   rd_mux = pin_out[p*WIDTH +: WIDTH];
          REG_DIR:   rd_mux = pin_oe[p*WIDTH +: WIDTH];
          REG_IE:    rd_mux = ie_all[p*WIDTH +: WIDTH];
          REG_IFLAG: rd_mux = iflag_all[p*WIDTH +: WIDTH];
          default:   rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
      irq <= |pend;
    end
  end

endmodule

// File: tb/tb_gpio_sfr_bank.sv
// Self-checking bench for gpio_sfr_bank (3 ports so an absent port index exists).
module tb_gpio_sfr_bank;
  import gpio_sfr_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned P  = 3;
  localparam int unsigned S  = 2;
  localparam int unsigned AW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AW-1:0]  addr;
  logic           wr_en, rd_en;
  logic [W-1:0]   wdata, rdata;
  logic           rvalid, irq;
  logic [P*W-1:0] pin_in, pin_out, pin_oe;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_sfr_bank #(.WIDTH(W), .PORTS(P), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .RST     (rst_n),
    .addr    (addr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain arrays, pads as a sample history.
  logic [W-1:0]   m_out [P];
  logic [W-1:0]   m_dir [P];
  logic [W-1:0]   m_ie [P];
  logic [W-1:0]   m_iflag [P];
  logic [P*W-1:0] m_hist [S+1];
  logic [W-1:0]   m_rdata;
  logic           m_rvalid, m_irq;

  task automatic model_step();
    logic [P*W-1:0] syn, prv;
    logic [W-1:0]   nf [P];
    int unsigned    port;
    logic [2:0]     r;
    logic           any;
    syn  = m_hist[S-1];
    prv  = m_hist[S];
    port = 32'(addr[4:3]);
    r    = addr[2:0];
    any  = 1'b0;
    for (int p = 0; p < P; p++) any = any | (|(m_iflag[p] & m_ie[p]));
    if (rd_en) begin
      m_rdata = '0;
      if (port < P) begin
        case (r)
          REG_IN:    m_rdata = syn[port*W +: W];
          REG_OUT:   m_rdata = m_out[port];
          REG_DIR:   m_rdata = m_dir[port];
          REG_IE:    m_rdata = m_ie[port];
          REG_IFLAG: m_rdata = m_iflag[port];
          default:   m_rdata = '0;
        endcase
      end
    end
    m_rvalid = rd_en;
    m_irq    = any;
    for (int p = 0; p < P; p++) nf[p] = (syn[p*W +: W] ^ prv[p*W +: W]) & m_ie[p];
    if (wr_en && port < P) begin
      case (r)
        REG_OUT:   m_out[port] = wdata;
        REG_DIR:   m_dir[port] = wdata;
        REG_IE:    m_ie[port] = wdata;
        REG_IFLAG: m_iflag[port] = m_iflag[port] & ~wdata;
        REG_SET:   m_out[port] = m_out[port] | wdata;
        REG_CLR:   m_out[port] = m_out[port] & ~wdata;
        REG_TGL:   m_out[port] = m_out[port] ^ wdata;
        default:   ;
      endcase
    end
    for (int p = 0; p < P; p++) m_iflag[p] = m_iflag[p] | nf[p];
    for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pin_in;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < P; p++) begin
        m_out[p] = '0; m_dir[p] = '0; m_ie[p] = '0; m_iflag[p] = '0;
      end
      for (int i = 0; i <= S; i++) m_hist[i] = '0;
      m_rdata = '0; m_rvalid = 1'b0; m_irq = 1'b0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("rdata", 64'(rdata), 64'(m_rdata));
    chk("rvalid", 64'(rvalid), 64'(m_rvalid));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("pin_out", 64'(pin_out), 64'({m_out[2], m_out[1], m_out[0]}));
    chk("pin_oe", 64'(pin_oe), 64'({m_dir[2], m_dir[1], m_dir[0]}));
  end

  task automatic wr(input int unsigned port, input logic [2:0] r, input logic [W-1:0] d);
    addr = {2'(port), r}; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int unsigned port, input logic [2:0] r,
                        input logic [W-1:0] exp);
    addr = {2'(port), r}; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk(name, 64'(rdata), 64'(exp));
    chk({name, "_rvalid"}, 64'(rvalid), 64'd1);
  endtask

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; pin_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pin_oe", 64'(pin_oe), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);

    // Asynchronous reset in the middle of a cycle with a read in flight.
    wr(0, REG_DIR, 16'hFFFF);
    wr(0, REG_OUT, 16'h5A5A);
    chk("dir_before_rst", 64'(pin_oe[15:0]), 64'h FFFF);
    chk("out_before_rst", 64'(pin_out[15:0]), 64'h5A5A);
    addr = {2'd0, REG_OUT}; rd_en = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", 64'(pin_oe), 64'd0);
    chk("async_rst_out", 64'(pin_out), 64'd0);
    chk("async_rst_irq", 64'(irq), 64'd0);
    @(negedge clk);
    rd_en = 1'b0;
    chk("no_rvalid_in_rst", 64'(rvalid), 64'd0);
    rst_n = 1'b1;
    rd_chk("in_after_rst", 0, REG_IN, 16'h0000);

    // Atomic set / clear / toggle on port 0.
    wr(0, REG_OUT, 16'h00F0);
    wr(0, REG_SET, 16'h0003);
    wr(0, REG_CLR, 16'h0010);
    wr(0, REG_TGL, 16'h8001);
    rd_chk("out_atomic", 0, REG_OUT, 16'h80E2);
    chk("pin_out_atomic", 64'(pin_out[15:0]), 64'h80E2);

    // Port 1 change interrupt: pad to irq latency.
    wr(1, REG_IE, 16'h0001);
    pin_in[16] = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq_c2", 64'(irq), 64'd0);
    rd_chk("in_sync", 1, REG_IN, 16'h0001);
    chk("irq_c3", 64'(irq), 64'd0);
    @(negedge clk);
    chk("irq_c4", 64'(irq), 64'd1);
    rd_chk("iflag_set", 1, REG_IFLAG, 16'h0001);
    wr(1, REG_IFLAG, 16'h0001);
    @(negedge clk);
    chk("irq_cleared", 64'(irq), 64'd0);
    rd_chk("iflag_clear", 1, REG_IFLAG, 16'h0000);

    // Hardware set coinciding with a W1C of the same bit.
    pin_in[16] = 1'b0;
    repeat (4) @(negedge clk);
    chk("irq_fall_edge", 64'(irq), 64'd1);
    pin_in[16] = 1'b1;
    repeat (2) @(negedge clk);
    wr(1, REG_IFLAG, 16'h0001);
    @(negedge clk);
    chk("irq_set_wins", 64'(irq), 64'd1);
    rd_chk("iflag_set_wins", 1, REG_IFLAG, 16'h0001);
    wr(1, REG_IFLAG, 16'h0001);
    @(negedge clk);
    chk("irq_final_clear", 64'(irq), 64'd0);

    // Masking via IE leaves IFLAG intact.
    wr(0, REG_IE, 16'h0004);
    pin_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    chk("irq_port0", 64'(irq), 64'd1);
    wr(0, REG_IE, 16'h0000);
    @(negedge clk);
    chk("irq_masked", 64'(irq), 64'd0);
    rd_chk("iflag_kept", 0, REG_IFLAG, 16'h0004);
    wr(0, REG_IFLAG, 16'hFFFF);

    // Read and write of the same register in one cycle.
    wr(0, REG_DIR, 16'h1234);
    addr = {2'd0, REG_DIR}; wdata = 16'hAAAA; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_old_value", 64'(rdata), 64'h1234);
    chk("rw_rvalid", 64'(rvalid), 64'd1);
    rd_chk("rw_new_value", 0, REG_DIR, 16'hAAAA);
    chk("rw_pin_oe", 64'(pin_oe[15:0]), 64'hAAAA);
    rd_chk("set_reads_zero", 0, REG_SET, 16'h0000);

    // Last real port and an absent port index.
    wr(2, REG_OUT, 16'hC3C3);
    wr(3, REG_OUT, 16'hFFFF);
    wr(3, REG_DIR, 16'hFFFF);
    chk("ports_out", 64'(pin_out), 64'hC3C3_0000_80E2);
    chk("ports_oe", 64'(pin_oe), 64'h0000_0000_AAAA);
    rd_chk("absent_port", 3, REG_OUT, 16'h0000);
    rd_chk("port2_out", 2, REG_OUT, 16'hC3C3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
